// File: rtl/lut_layer_sequencer_pkg.sv
// Shared types and helpers for the time-multiplexed LUT layer sequencer.
package lut_seq_pkg;

   localparam int unsigned FAN_IN    = 6;
   localparam int unsigned TT_W      = 64;
   // Widest fan-in index the layer can need (IN_W up to 1024).
   localparam int unsigned IDX_MAX_W = 10;

   typedef enum logic [1:0] {
      IDLE,
      EVAL,
      DONE
   } state_e;

   typedef logic [IDX_MAX_W-1:0] idx_t;
   typedef idx_t [FAN_IN-1:0]    fanin_t;

   // Unpack six fan-in indices of idx_w bits each; index k sits at [k*idx_w +: idx_w].
   // Bits of the word above FAN_IN*idx_w are never read.
   function automatic fanin_t unpack_conn(input logic [TT_W-1:0] word,
                                          input int unsigned     idx_w);
      fanin_t res;
      res = '0;
      for (int unsigned k = 0; k < FAN_IN; k++) begin
         for (int unsigned b = 0; b < IDX_MAX_W; b++) begin
            if (b < idx_w) begin
               res[k][b] = word[k*idx_w + b];
            end
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/lut_layer_sequencer_if.sv
// Configuration, input-stream and output-stream bundle of the LUT layer sequencer.
interface lut_layer_sequencer_if #(
   parameter int unsigned IN_W  = 64,
   parameter int unsigned NUM_N = 16,
   parameter int unsigned N_W   = $clog2(NUM_N)
);
   logic             cfg_we;
   logic             cfg_sel;
   logic [N_W-1:0]   cfg_addr;
   logic [63:0]      cfg_data;
   logic             cfg_err;
   logic             in_valid;
   logic             in_ready;
   logic [IN_W-1:0]  in_data;
   logic             out_valid;
   logic             out_ready;
   logic [NUM_N-1:0] out_data;
   logic             busy;

   // Producer / configuration side.
   modport master (
      output cfg_we, cfg_sel, cfg_addr, cfg_data, in_valid, in_data, out_ready,
      input  cfg_err, in_ready, out_valid, out_data, busy
   );

   // Sequencer side.
   modport slave (
      input  cfg_we, cfg_sel, cfg_addr, cfg_data, in_valid, in_data, out_ready,
      output cfg_err, in_ready, out_valid, out_data, busy
   );
endinterface

// File: rtl/lut_layer_sequencer_lut6.sv
// Runtime-loadable 6-input truth-table evaluator (one neuron's ROM, made writable).
module lut6_eval (
   input  logic [63:0] tt_i,
   input  logic [5:0]  addr_i,
   output logic        y_o
);
   assign y_o = tt_i[addr_i];
endmodule

// File: rtl/lut_layer_sequencer.sv
// Evaluates all neurons of a LogicNets layer with a single shared LUT6, one neuron per cycle.
module lut_layer_sequencer
   import lut_seq_pkg::*;
#(
   parameter int unsigned IN_W  = 64,
   parameter int unsigned NUM_N = 16,
   parameter int unsigned IDX_W = $clog2(IN_W),
   parameter int unsigned N_W   = $clog2(NUM_N)
) (
   input logic                  clk,
   input logic                  rst,
   lut_layer_sequencer_if.slave bus
);

   state_e              state_q, state_d;
   logic [N_W-1:0]      n_q;
   logic [IN_W-1:0]     in_q;
   logic [TT_W-1:0]     tt_q   [NUM_N];
   logic [TT_W-1:0]     conn_q [NUM_N];
   logic [NUM_N-1:0]    out_q;
   logic                out_valid_q;
   logic                cfg_err_q;

   logic                accept;
   logic                last_n;
   logic                addr_ok;
   logic                cfg_ok;
   logic                lut_y;
   logic [FAN_IN-1:0]   lut_addr;
   logic [IDX_W-1:0]    idx_k;
   fanin_t              fan;

   assign accept  = (state_q == IDLE) && bus.in_valid;
   assign last_n  = (32'(n_q) == NUM_N - 1);
   assign addr_ok = (32'(bus.cfg_addr) < NUM_N);
   // A write coincident with an accept still lands: the store is read from the next cycle on.
   assign cfg_ok  = bus.cfg_we && (state_q == IDLE) && addr_ok;

   // Gather the six fan-in bits of the current neuron into the LUT address.
   always_comb begin
      lut_addr = '0;
      idx_k    = '0;
      fan      = unpack_conn(conn_q[n_q], IDX_W);
      for (int unsigned k = 0; k < FAN_IN; k++) begin
         idx_k       = IDX_W'(fan[k]);
         lut_addr[k] = in_q[idx_k];
      end
   end

   lut6_eval u_lut (
      .tt_i   (tt_q[n_q]),
      .addr_i (lut_addr),
      .y_o    (lut_y)
   );

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.in_valid) state_d = EVAL;
         EVAL:    if (last_n)       state_d = DONE;
         DONE:    if (bus.out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs; both depend on registered state only.
   always_comb begin
      bus.in_ready = (state_q == IDLE);
      bus.busy     = (state_q != IDLE);
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_q;
   assign bus.cfg_err   = cfg_err_q;

   // Input capture, neuron counter, result vector and output-valid flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         n_q         <= '0;
         in_q        <= '0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         if (accept) begin
            in_q <= bus.in_data;
            n_q  <= '0;
         end else if (state_q == EVAL) begin
            out_q[n_q] <= lut_y;
            n_q        <= n_q + 1'b1;
         end
         if ((state_q == EVAL) && last_n) begin
            out_valid_q <= 1'b1;
         end else if ((state_q == DONE) && bus.out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   // Truth-table and connectivity stores plus the rejected-write pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < NUM_N; i++) begin
            tt_q[i]   <= '0;
            conn_q[i] <= '0;
         end
         cfg_err_q <= 1'b0;
      end else begin
         cfg_err_q <= bus.cfg_we && !cfg_ok;
         if (cfg_ok) begin
            if (bus.cfg_sel) begin
               conn_q[bus.cfg_addr] <= bus.cfg_data;
            end else begin
               tt_q[bus.cfg_addr] <= bus.cfg_data;
            end
         end
      end
   end

endmodule

// File: tb/tb_lut_layer_sequencer.sv
// Randomised self-checking bench for lut_layer_sequencer against a truth-table model.
module tb_lut_layer_sequencer;
   localparam int unsigned IN_W  = 64;
   localparam int unsigned NUM_N = 16;
   localparam int unsigned N_W   = 4;
   localparam int unsigned TMO   = 200;

   logic clk = 1'b0;
   logic rst = 1'b0;

   lut_layer_sequencer_if #(.IN_W(IN_W), .NUM_N(NUM_N)) bus ();
   lut_layer_sequencer #(.IN_W(IN_W), .NUM_N(NUM_N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Non-power-of-two layer so that out-of-range addresses are expressible.
   lut_layer_sequencer_if #(.IN_W(IN_W), .NUM_N(12)) bus2 ();
   lut_layer_sequencer #(.IN_W(IN_W), .NUM_N(12)) dut2 (
      .clk (clk),
      .rst (rst),
      .bus (bus2)
   );

   always #5 clk = ~clk;

   logic [63:0] tt_m   [NUM_N];
   int unsigned conn_m [NUM_N][6];
   int          n_checks = 0;
   int          n_pass   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic void model_clear();
      for (int n = 0; n < NUM_N; n++) begin
         tt_m[n] = '0;
         for (int k = 0; k < 6; k++) conn_m[n][k] = 0;
      end
   endfunction

   // Neuron n output = table[n] indexed by its six selected input bits (k=0 is LSB).
   function automatic logic [NUM_N-1:0] model_eval(input logic [IN_W-1:0] v);
      logic [NUM_N-1:0] r;
      int unsigned a;
      for (int n = 0; n < NUM_N; n++) begin
         a = 0;
         for (int k = 0; k < 6; k++) if (v[conn_m[n][k]]) a += (1 << k);
         r[n] = tt_m[n][a];
      end
      return r;
   endfunction

   task automatic cfg_write(input logic sel, input int unsigned n, input logic [63:0] data);
      bus.cfg_we = 1'b1; bus.cfg_sel = sel; bus.cfg_addr = N_W'(n); bus.cfg_data = data;
      tick();
      bus.cfg_we = 1'b0;
      check("cfg_err_accepted", bus.cfg_err, 0);
   endtask

   task automatic set_table(input int unsigned n, input logic [63:0] val);
      tt_m[n] = val;
      cfg_write(1'b0, n, val);
   endtask

   task automatic set_conn(input int unsigned n, input logic [5:0][5:0] idx, input logic [27:0] junk);
      for (int k = 0; k < 6; k++) conn_m[n][k] = idx[k];
      cfg_write(1'b1, n, {junk, idx});
   endtask

   task automatic wait_ready();
      int unsigned w = 0;
      while (!bus.in_ready && w < TMO) begin tick(); w++; end
      if (w >= TMO) check("in_ready_timeout", 0, 1);
   endtask

   task automatic wait_out(output logic [NUM_N-1:0] res);
      int unsigned w = 0;
      while (!bus.out_valid && w < TMO) begin tick(); w++; end
      if (w >= TMO) check("out_valid_timeout", 0, 1);
      res = bus.out_data;
   endtask

   task automatic accept_vec(input logic [IN_W-1:0] v);
      wait_ready();
      bus.in_valid = 1'b1; bus.in_data = v;
      tick();
      bus.in_valid = 1'b0;
   endtask

   task automatic run_vec(input logic [IN_W-1:0] v, output logic [NUM_N-1:0] res);
      accept_vec(v);
      wait_out(res);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
   endtask

   initial begin
      logic [NUM_N-1:0] res, res2;
      logic [IN_W-1:0]  v;
      logic [5:0][5:0]  idx;
      logic [63:0]      tv;

      bus.cfg_we = 0; bus.cfg_sel = 0; bus.cfg_addr = '0; bus.cfg_data = '0;
      bus.in_valid = 0; bus.in_data = '0; bus.out_ready = 0;
      bus2.cfg_we = 0; bus2.cfg_sel = 0; bus2.cfg_addr = '0; bus2.cfg_data = '0;
      bus2.in_valid = 0; bus2.in_data = '0; bus2.out_ready = 0;
      model_clear();

      #2 rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check("rst_in_ready", bus.in_ready, 1);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_data", bus.out_data, 0);
      check("rst_cfg_err", bus.cfg_err, 0);
      check("rst_busy", bus.busy, 0);

      // Selector LUT on neuron 0.
      set_table(0, 64'hAAAA_AAAA_AAAA_AAAA);
      idx = '0; idx[0] = 6'd5;
      set_conn(0, idx, 28'h0);
      run_vec(64'h20, res);
      check("sel_hi", res[0], 1);
      check("sel_hi_vec", res, model_eval(64'h20));
      run_vec(64'h0, res);
      check("sel_lo", res[0], 0);

      // Parity LUT on neuron 3; junk above the packed indices must be ignored.
      set_table(3, 64'h6996_9669_9669_6996);
      idx = {6'd5, 6'd4, 6'd3, 6'd2, 6'd1, 6'd0};
      set_conn(3, idx, 28'hFFF_FFFF);
      run_vec(64'b101100, res);
      check("parity_odd", res[3], 1);
      run_vec(64'b100100, res);
      check("parity_even", res[3], 0);
      check("parity_vec", res, model_eval(64'b100100));

      // Latency and in_ready profile with out_ready held high.
      wait_ready();
      v = {$urandom, $urandom};
      bus.out_ready = 1'b1;
      accept_vec(v);
      for (int i = 1; i <= NUM_N + 2; i++) begin
         check($sformatf("lat_out_valid_%0d", i), bus.out_valid, (i == NUM_N + 1) ? 1 : 0);
         check($sformatf("lat_in_ready_%0d", i), bus.in_ready, (i == NUM_N + 2) ? 1 : 0);
         if (i == NUM_N + 1) check("lat_data", bus.out_data, model_eval(v));
         if (i < NUM_N + 2) tick();
      end
      bus.out_ready = 1'b0;

      // Random tables and connectivity for every neuron.
      for (int n = 0; n < NUM_N; n++) begin
         set_table(n, {$urandom, $urandom});
         for (int k = 0; k < 6; k++) idx[k] = 6'($urandom_range(0, 63));
         set_conn(n, idx, 28'($urandom));
      end
      for (int t = 0; t < 10; t++) begin
         v = {$urandom, $urandom};
         run_vec(v, res);
         check($sformatf("rand_%0d", t), res, model_eval(v));
      end

      // Backpressure: result held while out_ready is low.
      v = {$urandom, $urandom};
      accept_vec(v);
      wait_out(res);
      check("bp_data", res, model_eval(v));
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bp_valid", bus.out_valid, 1);
         check("bp_stable", bus.out_data, res);
         check("bp_in_ready", bus.in_ready, 0);
      end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check("bp_idle_busy", bus.busy, 0);
      check("bp_idle_ready", bus.in_ready, 1);
      check("bp_idle_valid", bus.out_valid, 0);

      // Config write coincident with accept is used by that very run.
      v = {$urandom, $urandom};
      tv = {$urandom, $urandom};
      tt_m[4] = tv;
      bus.cfg_we = 1'b1; bus.cfg_sel = 1'b0; bus.cfg_addr = 4'd4; bus.cfg_data = tv;
      bus.in_valid = 1'b1; bus.in_data = v;
      tick();
      bus.cfg_we = 1'b0; bus.in_valid = 1'b0;
      check("coinc_cfg_err", bus.cfg_err, 0);
      wait_out(res);
      bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0;
      check("coinc_data", res, model_eval(v));

      // Write while busy is rejected with a single-cycle error pulse.
      v = {$urandom, $urandom};
      accept_vec(v);
      tick(); tick();
      bus.cfg_we = 1'b1; bus.cfg_sel = 1'b0; bus.cfg_addr = 4'd2; bus.cfg_data = ~tt_m[2];
      tick();
      bus.cfg_we = 1'b0;
      check("busy_err_pulse", bus.cfg_err, 1);
      tick();
      check("busy_err_clear", bus.cfg_err, 0);
      wait_out(res);
      bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0;
      check("busy_rej_data", res, model_eval(v));
      run_vec(v, res2);
      check("busy_rerun", res2, res);

      // Out-of-range neuron address on the 12-neuron instance.
      for (int a = 11; a < 16; a += 2) begin
         bus2.cfg_we = 1'b1; bus2.cfg_addr = 4'(a); bus2.cfg_data = {$urandom, $urandom};
         tick();
         bus2.cfg_we = 1'b0;
         check($sformatf("addr_err_%0d", a), bus2.cfg_err, (a >= 12) ? 1 : 0);
         tick();
         check($sformatf("addr_err_clear_%0d", a), bus2.cfg_err, 0);
      end

      // Reset in the middle of evaluation.
      v = {$urandom, $urandom};
      accept_vec(v);
      repeat (7) tick();
      check("midrst_busy_pre", bus.busy, 1);
      rst = 1'b1;
      #1;
      check("midrst_valid", bus.out_valid, 0);
      check("midrst_busy", bus.busy, 0);
      model_clear();
      @(posedge clk);
      #1 rst = 1'b0;
      check("midrst_ready", bus.in_ready, 1);
      check("midrst_out_data", bus.out_data, 0);
      v = {$urandom, $urandom};
      run_vec(v, res);
      check("midrst_run", res, 0);
      check("midrst_run_model", res, model_eval(v));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/lut_layer_sequencer.md
Name: lut_layer_sequencer

Overview:
- Time-multiplexes one runtime-loadable 6-input truth-table evaluator across all NUM_N neurons of a LogicNets layer.
- Each neuron has a 64-bit truth table and six fan-in indices, both held in configuration registers.
- On each accepted input vector, the block evaluates neurons 0..NUM_N-1, one per cycle, and presents the packed result vector on a valid/ready output.
- Sits between layer input/output streams where area matters more than latency (an alternative to one unrolled ROM per neuron).

Parameters:
IN_W, 64, layer input vector width (power of two, 8..1024)
NUM_N, 16, neurons in layer (2..256)
IDX_W, $clog2(IN_W), fan-in index width; 6*IDX_W must be <= 64
N_W, $clog2(NUM_N), neuron address width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
cfg_we  in  1  config write strobe
cfg_sel  in  1  0 = truth table, 1 = connectivity
cfg_addr  in  N_W  neuron index
cfg_data  in  64  table word, or packed indices (idx_k at bits [k*IDX_W +: IDX_W])
cfg_err  out  1  one-cycle pulse: write rejected
in_valid  in  1  input vector valid
in_ready  out  1  sequencer can accept
in_data  in  IN_W  layer input vector
out_valid  out  1  result valid
out_ready  in  1  downstream accepts
out_data  out  NUM_N  bit n = neuron n output
busy  out  1  state != IDLE

Behaviour:
Reset (async, active-high):
- state=IDLE, neuron counter=0, out_valid=0, out_data=0, cfg_err=0.
- All truth tables and connectivity cleared to 0; captured input cleared.
- Reset mid-operation discards the in-flight vector with no output. in_ready=1 in the first cycle after release.

FSM states: IDLE, EVAL, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: capture in_data, n<=0, go EVAL.
  - cfg_we with cfg_addr<NUM_N writes the selected store at that edge.
- EVAL:
  - in_ready=0.
  - Each cycle: addr[k] = in_reg[conn[n].idx_k] for k=0..5 (k=0 is addr LSB); out_data[n] <= table[n][addr]; n<=n+1.
  - When n==NUM_N-1, go DONE and set out_valid<=1 at the same edge.
- DONE:
  - out_valid=1; out_data stable; in_ready=0.
  - On out_ready, clear out_valid and go IDLE.
  - out_data keeps its value until the next run overwrites it.

Latency and throughput:
- Accept edge at cycle t. out_valid is high from cycle t+NUM_N+1.
- Peak throughput: one vector per NUM_N+2 cycles with out_ready tied high.

Config rules:
- cfg_we while busy, or with cfg_addr>=NUM_N: write ignored; cfg_err=1 for the next cycle only.
- cfg_we coincident with an IDLE accept: the write takes effect, and evaluation uses the updated store.
- Bits of cfg_data above 6*IDX_W are ignored for connectivity writes.

No combinational path from in_valid to in_ready, or from out_ready to out_valid.

Decomposition:
- Package lut_seq_pkg:
  - state enum (IDLE/EVAL/DONE)
  - FAN_IN=6 and TT_W=64
  - function to unpack the six indices from a 64-bit config word
- Sub-module lut6_eval: purely combinational; 64-bit table plus 6-bit address in, 1 bit out. It is the runtime-loadable counterpart of a fixed neuron ROM.
- Top level holds the FSM, counter, config stores and handshakes.

Test Plan:
1. Select LUT:
   - Stimulus: table0=64'hAAAA_AAAA_AAAA_AAAA; conn0 idx0=5 (others 0). Run in_data with bit5=1, then bit5=0.
   - Expect: out_data[0]=1, then 0.
2. Parity:
   - Stimulus: table3=64'h6996_9669_9669_6996; conn3 idx0..5=0..5; in_data[5:0]=6'b101100.
   - Expect: out_data[3]=1. With in_data[5:0]=6'b100100, expect out_data[3]=0.
3. Latency (NUM_N=16):
   - Stimulus: accept at cycle 10, out_ready held high.
   - Expect: out_valid first high at cycle 27; in_ready low cycles 11..27; in_ready=1 at cycle 28.
4. Backpressure:
   - Stimulus: out_ready low for 5 cycles after out_valid rises.
   - Expect: out_valid and out_data stable; in_ready=0 throughout; IDLE one cycle after the out_ready handshake.
5. Rejected config:
   - Stimulus: cfg_we during EVAL; separately cfg_addr=NUM_N while IDLE.
   - Expect: cfg_err exactly one cycle each time; rerunning the same vector gives an identical out_data.
6. Reset mid-run:
   - Stimulus: assert rst while n=7 in EVAL.
   - Expect: out_valid=0 and busy=0 immediately; in_ready=1 after release; next run with no config gives out_data=0.
